// File: rtl/c_tokenizer_if.sv
// Byte-in / token-out bus of the C tokenizer.
// master = byte source and token sink, slave = tokenizer.
interface c_tokenizer_if #(
    parameter int MAX_ID_LEN = 8,
    parameter int NUM_W      = 32,
    parameter int POS_W      = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [7:0]              in_byte;
    logic                    out_valid;
    logic                    out_ready;
    logic [1:0]              tok_kind;
    logic [8*MAX_ID_LEN-1:0] tok_str;
    logic [3:0]              tok_len;
    logic [NUM_W-1:0]        tok_num;
    logic [POS_W-1:0]        tok_pos;
    logic                    err;
    logic [1:0]              err_code;

    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, tok_kind, tok_str, tok_len, tok_num, tok_pos, err, err_code
    );

    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, tok_kind, tok_str, tok_len, tok_num, tok_pos, err, err_code
    );
endinterface

// File: rtl/c_tokenizer.sv
// Streaming C lexer: one source byte in per cycle, one token out per handshake.
// Define C_TOKENIZER_COMMENT_EN to recognise // and /* */ comments.
module c_tokenizer #(
    parameter int MAX_ID_LEN = 8,
    parameter int NUM_W      = 32,
    parameter int POS_W      = 16
) (
    input logic          clk,
    input logic          rst_n,
    c_tokenizer_if.slave bus
);
    localparam int STR_W = 8 * MAX_ID_LEN;

    localparam logic [3:0] S_SKIP   = 4'd0;
    localparam logic [3:0] S_IDENT  = 4'd1;
    localparam logic [3:0] S_NUM    = 4'd2;
    localparam logic [3:0] S_PUNCT2 = 4'd3;
    localparam logic [3:0] S_EMIT   = 4'd4;
    localparam logic [3:0] S_DONE   = 4'd5;
    localparam logic [3:0] S_ERR    = 4'd6;
`ifdef C_TOKENIZER_COMMENT_EN
    localparam logic [3:0] S_SLASH  = 4'd7;
    localparam logic [3:0] S_LCOMM  = 4'd8;
    localparam logic [3:0] S_BCOMM  = 4'd9;
    localparam logic [3:0] S_BSTAR  = 4'd10;
    localparam logic [1:0] E_COMM   = 2'd3;
`endif

    localparam logic [1:0] K_RSV  = 2'd0;
    localparam logic [1:0] K_ID   = 2'd1;
    localparam logic [1:0] K_NUM  = 2'd2;
    localparam logic [1:0] K_EOF  = 2'd3;
    localparam logic [1:0] E_CHAR = 2'd1;
    localparam logic [1:0] E_LONG = 2'd2;

    function automatic logic is_alpha(input logic [7:0] c);
        return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z") || (c == "_");
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= "0" && c <= "9");
    endfunction

    function automatic logic is_space(input logic [7:0] c);
        return (c == " ") || (c == 8'h09) || (c == 8'h0a) || (c == 8'h0d);
    endfunction

    function automatic logic is_punct1(input logic [7:0] c);
        return (c == "+") || (c == "-") || (c == "*") || (c == "/") || (c == "(") ||
               (c == ")") || (c == "{") || (c == "}") || (c == "[") || (c == "]") ||
               (c == ";") || (c == ",") || (c == "&");
    endfunction

    function automatic logic is_punct2(input logic [7:0] c);
        return (c == "=") || (c == "!") || (c == "<") || (c == ">");
    endfunction

    // Text is packed first-char-low, so keyword literals appear byte-reversed.
    function automatic logic is_kw(input logic [47:0] s, input logic [3:0] n);
        case (n)
            4'd2:    return (s[15:0] == "fi");
            4'd3:    return (s[23:0] == "tni") || (s[23:0] == "rof");
            4'd4:    return (s[31:0] == "esle");
            4'd5:    return (s[39:0] == "elihw");
            4'd6:    return (s[47:0] == "nruter") || (s[47:0] == "foezis");
            default: return 1'b0;
        endcase
    endfunction

    logic [3:0]       state_q, state_d;
    logic             hold_vld_q, hold_vld_d;
    logic [7:0]       hold_byte_q, hold_byte_d;
    logic [1:0]       kind_q, kind_d;
    logic [STR_W-1:0] str_q, str_d;
    logic [3:0]       len_q, len_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [POS_W-1:0] tpos_q, tpos_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;

    logic             active, in_ready, use_hold, take_in;
    logic [7:0]       b;
    logic [POS_W-1:0] cur_pos;
    logic             mk_start, mk_hold, mk_eof, mk_err;
    logic [1:0]       err_c;

    assign active   = (state_q != S_EMIT) && (state_q != S_DONE) && (state_q != S_ERR);
    assign in_ready = rst_n && active && !hold_vld_q;
    assign use_hold = active && hold_vld_q;
    assign take_in  = bus.in_valid && in_ready;
    assign b        = use_hold ? hold_byte_q : bus.in_byte;
    // A held byte was the last one accepted, so it sits one behind the counter.
    assign cur_pos  = use_hold ? pos_q - POS_W'(1) : pos_q;

    always_comb begin
        state_d     = state_q;
        hold_vld_d  = hold_vld_q;
        hold_byte_d = hold_byte_q;
        kind_d      = kind_q;
        str_d       = str_q;
        len_d       = len_q;
        num_d       = num_q;
        tpos_d      = tpos_q;
        pos_d       = pos_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        mk_start    = 1'b0;
        mk_hold     = 1'b0;
        mk_eof      = 1'b0;
        mk_err      = 1'b0;
        err_c       = E_CHAR;

        if (take_in) pos_d = pos_q + POS_W'(1);
        if (use_hold) hold_vld_d = 1'b0;

        if (state_q == S_EMIT) begin
            if (bus.out_ready) state_d = (kind_q == K_EOF) ? S_DONE : S_SKIP;
        end else if (use_hold || take_in) begin
            case (state_q)
                S_SKIP: begin
                    if (is_alpha(b)) begin
                        mk_start = 1'b1; kind_d = K_ID; state_d = S_IDENT;
                    end else if (is_digit(b)) begin
                        mk_start = 1'b1; kind_d = K_NUM; state_d = S_NUM;
                    end else if (is_punct2(b)) begin
                        mk_start = 1'b1; kind_d = K_RSV; state_d = S_PUNCT2;
`ifdef C_TOKENIZER_COMMENT_EN
                    end else if (b == "/") begin
                        mk_start = 1'b1; kind_d = K_RSV; state_d = S_SLASH;
`endif
                    end else if (is_punct1(b)) begin
                        mk_start = 1'b1; kind_d = K_RSV; state_d = S_EMIT;
                    end else if (b == 8'h00) begin
                        mk_eof = 1'b1;
                    end else if (!is_space(b)) begin
                        mk_err = 1'b1;
                    end
                end
                S_IDENT: begin
                    if (is_alpha(b) || is_digit(b)) begin
                        if (len_q == 4'(MAX_ID_LEN)) begin
                            mk_err = 1'b1; err_c = E_LONG;
                        end else begin
                            str_d = str_q | (STR_W'(b) << (8 * len_q));
                            len_d = len_q + 4'd1;
                        end
                    end else begin
                        kind_d  = is_kw(str_q[47:0], len_q) ? K_RSV : K_ID;
                        mk_hold = 1'b1;
                        state_d = S_EMIT;
                    end
                end
                S_NUM: begin
                    if (is_digit(b)) begin
                        num_d = num_q * NUM_W'(10) + NUM_W'(b - 8'h30);
                        if (len_q < 4'(MAX_ID_LEN)) begin
                            str_d = str_q | (STR_W'(b) << (8 * len_q));
                            len_d = len_q + 4'd1;
                        end
                    end else begin
                        mk_hold = 1'b1; state_d = S_EMIT;
                    end
                end
                S_PUNCT2: begin
                    if (b == "=") begin
                        str_d[15:8] = b; len_d = 4'd2; state_d = S_EMIT;
                    end else if (str_q[7:0] == "!") begin
                        mk_err = 1'b1;
                    end else begin
                        mk_hold = 1'b1; state_d = S_EMIT;
                    end
                end
`ifdef C_TOKENIZER_COMMENT_EN
                S_SLASH: begin
                    if (b == "/")      state_d = S_LCOMM;
                    else if (b == "*") state_d = S_BCOMM;
                    else begin
                        mk_hold = 1'b1; state_d = S_EMIT;
                    end
                end
                S_LCOMM: begin
                    if (b == 8'h0a)      state_d = S_SKIP;
                    else if (b == 8'h00) mk_eof = 1'b1;
                end
                S_BCOMM: begin
                    if (b == "*") state_d = S_BSTAR;
                    else if (b == 8'h00) begin
                        mk_err = 1'b1; err_c = E_COMM;
                    end
                end
                S_BSTAR: begin
                    if (b == "/") state_d = S_SKIP;
                    else if (b == 8'h00) begin
                        mk_err = 1'b1; err_c = E_COMM;
                    end else if (b != "*") state_d = S_BCOMM;
                end
`endif
                default: state_d = state_q;
            endcase
        end

        if (mk_start) begin
            str_d  = STR_W'(b);
            len_d  = 4'd1;
            num_d  = is_digit(b) ? NUM_W'(b - 8'h30) : '0;
            tpos_d = cur_pos;
        end
        if (mk_hold) begin
            hold_vld_d  = 1'b1;
            hold_byte_d = b;
        end
        if (mk_eof) begin
            kind_d  = K_EOF;
            str_d   = '0;
            len_d   = 4'd0;
            num_d   = '0;
            tpos_d  = cur_pos;
            state_d = S_EMIT;
        end
        if (mk_err) begin
            err_d      = 1'b1;
            err_code_d = err_c;
            state_d    = S_ERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_SKIP;
            hold_vld_q  <= 1'b0;
            hold_byte_q <= 8'h00;
            kind_q      <= 2'd0;
            str_q       <= '0;
            len_q       <= 4'd0;
            num_q       <= '0;
            tpos_q      <= '0;
            pos_q       <= '0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            hold_vld_q  <= hold_vld_d;
            hold_byte_q <= hold_byte_d;
            kind_q      <= kind_d;
            str_q       <= str_d;
            len_q       <= len_d;
            num_q       <= num_d;
            tpos_q      <= tpos_d;
            pos_q       <= pos_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == S_EMIT);
    assign bus.tok_kind  = kind_q;
    assign bus.tok_str   = str_q;
    assign bus.tok_len   = len_q;
    assign bus.tok_num   = num_q;
    assign bus.tok_pos   = tpos_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_c_tokenizer.sv
// Directed bench for c_tokenizer: table of source streams with expected token lists,
// plus a hand-written reset-while-token-pending sequence.
module tb_c_tokenizer;
    localparam int MAX_ID_LEN = 8;
    localparam int NUM_W      = 32;
    localparam int POS_W      = 16;
    localparam int NTOK       = 10;
    localparam int SRC_CH     = 40;
    localparam logic [1:0] KR = 2'd0, KI = 2'd1, KN = 2'd2, KE = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] str;
        logic [3:0]  len;
        logic [31:0] num;
        logic [15:0] pos;
    } tok_t;

    typedef struct {
        logic [8*SRC_CH-1:0] src;
        int                  src_len;
        bit                  add_nul;
        logic [3:0]          rdy_pat;
        int                  ntok;
        tok_t [NTOK-1:0]     toks;
        bit                  exp_err;
        logic [1:0]          exp_code;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    c_tokenizer_if #(.MAX_ID_LEN(MAX_ID_LEN), .NUM_W(NUM_W), .POS_W(POS_W)) bus ();

    c_tokenizer #(.MAX_ID_LEN(MAX_ID_LEN), .NUM_W(NUM_W), .POS_W(POS_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] le(input logic [63:0] lit, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = lit[8*(n-1-i) +: 8];
        return r;
    endfunction

    function automatic tok_t mk(input logic [1:0] k, input logic [63:0] lit, input int n,
                                input logic [31:0] v, input logic [15:0] p);
        tok_t t;
        t.kind = k; t.str = le(lit, n); t.len = 4'(n); t.num = v; t.pos = p;
        return t;
    endfunction

    function automatic vec_t nv(input logic [8*SRC_CH-1:0] s, input int l, input bit nul,
                                input logic [3:0] pat);
        vec_t x;
        x.src = s; x.src_len = l; x.add_nul = nul; x.rdy_pat = pat;
        x.ntok = 0; x.toks = '0; x.exp_err = 1'b0; x.exp_code = 2'd0;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_byte   = 8'h00;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset outputs", {bus.out_valid, bus.in_ready, bus.tok_kind, bus.tok_str, bus.tok_len,
                              bus.tok_num, bus.tok_pos, bus.err, bus.err_code}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input int vi, input vec_t x);
        int   idx, tk, total, budget;
        bit   stall, acc_in;
        tok_t prev, cur;
        total  = x.src_len + (x.add_nul ? 1 : 0);
        budget = 4 * (total + x.ntok) + 20;
        do_reset();
        idx = 0; tk = 0; stall = 1'b0; prev = '0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (idx < total) begin
                bus.in_valid = 1'b1;
                bus.in_byte  = (idx < x.src_len) ? x.src[8*(x.src_len-1-idx) +: 8] : 8'h00;
            end else begin
                bus.in_valid = 1'b0;
                bus.in_byte  = 8'h00;
            end
            bus.out_ready = x.rdy_pat[cyc % 4];
            #1;
            cur = {bus.tok_kind, bus.tok_str, bus.tok_len, bus.tok_num, bus.tok_pos};
            if (stall) chk($sformatf("v%0d stalled token stable", vi), {bus.out_valid, cur}, {1'b1, prev});
            stall = bus.out_valid && !bus.out_ready;
            prev  = cur;
            if (bus.out_valid && bus.out_ready) begin
                if (tk < x.ntok) chk($sformatf("v%0d token%0d", vi, tk), cur, x.toks[tk]);
                tk++;
            end
            acc_in = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (acc_in) idx++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #1;
        chk($sformatf("v%0d token count", vi), tk, x.ntok);
        chk($sformatf("v%0d final err/code", vi), {bus.err, bus.err_code}, {x.exp_err, x.exp_code});
        chk($sformatf("v%0d final in_ready/out_valid", vi), {bus.in_ready, bus.out_valid}, 2'b00);
    endtask

    vec_t vecs[$];
    vec_t t;

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_byte = 8'h00; bus.out_ready = 1'b0;

        t = nv("int x;", 6, 1'b1, 4'b1111);
        t.toks[0] = mk(KR, "int", 3, 0, 0); t.toks[1] = mk(KI, "x", 1, 0, 4);
        t.toks[2] = mk(KR, ";", 1, 0, 5);   t.toks[3] = mk(KE, 64'd0, 0, 0, 6);
        t.ntok = 4; vecs.push_back(t);

        t = nv("a>=10", 5, 1'b1, 4'b1001);
        t.toks[0] = mk(KI, "a", 1, 0, 0);   t.toks[1] = mk(KR, ">=", 2, 0, 1);
        t.toks[2] = mk(KN, "10", 2, 10, 3); t.toks[3] = mk(KE, 64'd0, 0, 0, 5);
        t.ntok = 4; vecs.push_back(t);

        t = nv("y!=4294967297;", 14, 1'b1, 4'b1111);
        t.toks[0] = mk(KI, "y", 1, 0, 0);   t.toks[1] = mk(KR, "!=", 2, 0, 1);
        t.toks[2] = mk(KN, "42949672", 8, 1, 3);
        t.toks[3] = mk(KR, ";", 1, 0, 13);  t.toks[4] = mk(KE, 64'd0, 0, 0, 14);
        t.ntok = 5; vecs.push_back(t);

        t = nv("abcdefghi", 9, 1'b1, 4'b1111);
        t.exp_err = 1'b1; t.exp_code = 2'd2; vecs.push_back(t);

        t = nv("x$", 2, 1'b1, 4'b1111);
        t.toks[0] = mk(KI, "x", 1, 0, 0); t.ntok = 1;
        t.exp_err = 1'b1; t.exp_code = 2'd1; vecs.push_back(t);

        t = nv("!a", 2, 1'b0, 4'b1111);
        t.exp_err = 1'b1; t.exp_code = 2'd1; vecs.push_back(t);

        t = nv("while sizeof return if else for foo", 35, 1'b1, 4'b1111);
        t.toks[0] = mk(KR, "while", 5, 0, 0);   t.toks[1] = mk(KR, "sizeof", 6, 0, 6);
        t.toks[2] = mk(KR, "return", 6, 0, 13); t.toks[3] = mk(KR, "if", 2, 0, 20);
        t.toks[4] = mk(KR, "else", 4, 0, 23);   t.toks[5] = mk(KR, "for", 3, 0, 28);
        t.toks[6] = mk(KI, "foo", 3, 0, 32);    t.toks[7] = mk(KE, 64'd0, 0, 0, 35);
        t.ntok = 8; vecs.push_back(t);

        t = nv({"(<5>x)", 8'h09, "/=", 8'h0d, "&"}, 11, 1'b1, 4'b0110);
        t.toks[0] = mk(KR, "(", 1, 0, 0); t.toks[1] = mk(KR, "<", 1, 0, 1);
        t.toks[2] = mk(KN, "5", 1, 5, 2); t.toks[3] = mk(KR, ">", 1, 0, 3);
        t.toks[4] = mk(KI, "x", 1, 0, 4); t.toks[5] = mk(KR, ")", 1, 0, 5);
        t.toks[6] = mk(KR, "/", 1, 0, 7); t.toks[7] = mk(KR, "=", 1, 0, 8);
        t.toks[8] = mk(KR, "&", 1, 0, 10); t.toks[9] = mk(KE, 64'd0, 0, 0, 11);
        t.ntok = 10; vecs.push_back(t);

`ifdef C_TOKENIZER_COMMENT_EN
        t = nv({"a/*c*/b//z", 8'h0a, "c/"}, 13, 1'b1, 4'b1111);
        t.toks[0] = mk(KI, "a", 1, 0, 0);  t.toks[1] = mk(KI, "b", 1, 0, 6);
        t.toks[2] = mk(KI, "c", 1, 0, 11); t.toks[3] = mk(KR, "/", 1, 0, 12);
        t.toks[4] = mk(KE, 64'd0, 0, 0, 13);
        t.ntok = 5; vecs.push_back(t);

        t = nv("/*x", 3, 1'b1, 4'b1111);
        t.exp_err = 1'b1; t.exp_code = 2'd3; vecs.push_back(t);

        t = nv("//q", 3, 1'b1, 4'b1111);
        t.toks[0] = mk(KE, 64'd0, 0, 0, 3); t.ntok = 1; vecs.push_back(t);
`endif

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Reset while a token is waiting for the parser.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_byte  = (i == 0) ? "a" : (i == 1) ? "b" : " ";
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("pending token", {bus.out_valid, bus.tok_kind, bus.tok_len, bus.tok_str, bus.in_ready},
            {1'b1, KI, 4'd2, le("ab", 2), 1'b0});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset mid-handshake", {bus.out_valid, bus.in_ready, bus.tok_len, bus.tok_str,
                                          bus.tok_pos, bus.err}, '0);
        @(negedge clk);

        t = nv("q", 1, 1'b1, 4'b1111);
        t.toks[0] = mk(KI, "q", 1, 0, 0); t.toks[1] = mk(KE, 64'd0, 0, 0, 1);
        t.ntok = 2;
        run_vec(99, t);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/c_tokenizer.md
# c_tokenizer

Streaming lexer that converts C source bytes into the token stream consumed by the parser stage: reserved words and punctuators, identifiers, decimal numbers and a final end-of-file token. It sits directly upstream of the parser. It accepts one byte per cycle over a valid/ready handshake and emits one token per handshake. Each token carries its kind, packed text, numeric value and source offset for error reporting.

## Interface
- MAX_ID_LEN, 8, maximum identifier/keyword length in bytes
- NUM_W, 32, width of numeric token value
- POS_W, 16, width of source byte offset
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  source byte valid
- in_ready  out  1  tokenizer accepts byte this cycle
- in_byte  in  8  ASCII source byte; 0x00 marks end of source
- out_valid  out  1  token valid
- out_ready  in  1  parser accepts token
- tok_kind  out  2  0=reserved, 1=ident, 2=num, 3=eof
- tok_str  out  8*MAX_ID_LEN  token text; first char in [7:0], zero padded
- tok_len  out  4  text length in bytes; 0 for eof
- tok_num  out  NUM_W  value for num tokens, else 0
- tok_pos  out  POS_W  0-based offset of first byte of token
- err  out  1  sticky lexical error
- err_code  out  2  1=bad char, 2=identifier too long, 3=unterminated comment

## Operation
- States: SKIP, IDENT, NUM, PUNCT2, SLASH*, LCOMM*, BCOMM*, BSTAR*, EMIT, DONE, ERR. States marked * exist only with the comment feature.
- SKIP discards space, \t, \n and \r. [A-Za-z_] enters IDENT and 0-9 enters NUM. Any of = ! < > enters PUNCT2. Any of + - * / ( ) { } [ ] ; , & goes to EMIT as a 1-char reserved token. 0x00 emits an eof token, then DONE. Any other byte goes to ERR with code 1.
- IDENT appends [A-Za-z0-9_]. The (MAX_ID_LEN+1)th char goes to ERR with code 2. A terminating byte ends the token.
- Keyword match on termination: int, return, if, else, for, while, sizeof give kind 0; otherwise kind 1.
- NUM: value = value*10 + digit, truncated mod 2^NUM_W with no error. tok_str holds the first MAX_ID_LEN digits.
- PUNCT2: a next byte of '=' gives a 2-char token (==, !=, <=, >=) and the byte is consumed. Otherwise a single-char token is emitted and the byte is held. A lone '!' goes to ERR with code 1.
- Lookahead: a byte that terminates a token is stored in a 1-entry hold register. It is reprocessed from SKIP after the token handshake and is not requested again.
- EMIT holds every token field stable while out_valid && !out_ready.
- DONE: in_ready=0 and out_valid=0 until reset.
- ERR: err=1 and err_code latched, in_ready=0, out_valid=0, until reset. A pending token is dropped.
- tok_pos counts accepted bytes, wrapping mod 2^POS_W.

## Timing
- Reset values: out_valid 0, in_ready 0 while rst_n low, all tok_* fields 0, err 0, err_code 0, hold empty, state SKIP.
- in_ready is 1 in SKIP/IDENT/NUM/PUNCT2 (and comment states) only while the hold register is empty and no token is pending.
- A byte is accepted on in_valid && in_ready. A token is accepted on out_valid && out_ready.
- Latency: out_valid rises the cycle after the byte that completes or terminates a token is accepted. Held-byte reprocessing costs no extra cycle: the cycle after the token handshake behaves as if that byte were arriving.
- Throughput: one byte per cycle inside a token. Each token costs at least one cycle of in_ready=0.
- Reset mid-token or mid-handshake: everything is aborted immediately and the partial token is lost.

## Configuration
- C_TOKENIZER_COMMENT_EN defined: '/' enters SLASH.
  - A second '/' enters LCOMM, which runs until \n. 0x00 in LCOMM emits eof.
  - '*' enters BCOMM, which runs until the sequence "*/" via BSTAR. 0x00 in BCOMM or BSTAR goes to ERR with code 3.
  - Any other byte emits '/' and is held.
  - Comment bytes advance tok_pos but produce no token.
- Not defined: '/' is always a 1-char reserved token and comments are not recognised.

## Test plan
- "int x;\0" -> tokens reserved"int"@0, ident"x"@4, reserved";"@5, eof@6; then DONE with in_ready=0.
- "a>=10\0" with out_ready toggling 1,0,0,1 -> ident"a", reserved">=", num 10, eof; fields stable while stalled.
- "y!=4294967297;\0" (NUM_W=32) -> ident"y", reserved"!=", num tok_num=1, reserved";", eof.
- "abcdefghi\0" (MAX_ID_LEN=8) -> no token, err=1, err_code=2, in_ready=0; rst_n pulse mid-stream clears all outputs to 0.
- "x$\0" -> ident"x", then err_code=1 on '$'. "!a" -> err_code=1.
- With C_TOKENIZER_COMMENT_EN: "a/*c*/b//z\nc/\0" -> ident"a", ident"b"@6, ident"c"@11, reserved"/"@12, eof@13. "/*x\0" -> err_code=3.
